// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing a single-port main memory between two
// picorv32-style iomem requesters, with a fixed-latency access sequencer.
module mem_port_arbiter #(
  parameter int unsigned RAM_DELAY     = 16,
  parameter logic [31:0] RAM_BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] RAM_MASK_ADDR = 32'h00ff_ffff,
  parameter int unsigned ADDR_W        = 18
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              m0_valid,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_wr_strb,
  output logic              ram_rd_en,
  input  logic [31:0]       ram_rdata,
  output logic              busy_o,
  output logic              decode_err_o
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp, StErr} state_e;

  localparam logic [7:0] CntInit = 8'(RAM_DELAY - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        prio_q;   // 1: m1 wins a tie on the next grant
  logic        gnt_q;    // requester owning the current access
  logic [3:0]  wstrb_q;

  logic        gnt_m1;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        in_win;

  // Pick the requester to grant and decode its address window.
  always_comb begin
    gnt_m1 = 1'b0;
    if (m0_valid && m1_valid) begin
      gnt_m1 = prio_q;
    end else begin
      gnt_m1 = m1_valid;
    end
    req_addr  = gnt_m1 ? m1_addr  : m0_addr;
    req_wdata = gnt_m1 ? m1_wdata : m0_wdata;
    req_wstrb = gnt_m1 ? m1_wstrb : m0_wstrb;
    in_win    = (req_addr & ~RAM_MASK_ADDR) == RAM_BASE_ADDR;
  end

  // Access sequencer; every output except busy_o is a register.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      prio_q       <= 1'b0;
      gnt_q        <= 1'b0;
      wstrb_q      <= '0;
      m0_ready     <= 1'b0;
      m0_rdata     <= '0;
      m1_ready     <= 1'b0;
      m1_rdata     <= '0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_wr_strb  <= '0;
      ram_rd_en    <= 1'b0;
      decode_err_o <= 1'b0;
    end else begin
      // RAM strobes are single-cycle pulses.
      ram_wr_strb <= '0;
      ram_rd_en   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (m0_valid || m1_valid) begin
            gnt_q     <= gnt_m1;
            prio_q    <= ~gnt_m1;
            wstrb_q   <= req_wstrb;
            ram_addr  <= req_addr[ADDR_W+1:2];
            ram_wdata <= req_wdata;
            if (in_win) begin
              state_q <= StAccess;
              cnt_q   <= CntInit;
              if (req_wstrb == 4'b0000) begin
                ram_rd_en <= 1'b1;
              end else begin
                ram_wr_strb <= req_wstrb;
              end
            end else begin
              // Out-of-window: answer next cycle with zero data, no RAM strobe.
              state_q      <= StErr;
              decode_err_o <= 1'b1;
              m0_ready     <= ~gnt_m1;
              m1_ready     <= gnt_m1;
            end
          end
        end
        StAccess: begin
          if (cnt_q == 8'd0) begin
            state_q <= StResp;
            if (gnt_q) begin
              m1_ready <= 1'b1;
              m1_rdata <= (wstrb_q == 4'b0000) ? ram_rdata : 32'h0;
            end else begin
              m0_ready <= 1'b1;
              m0_rdata <= (wstrb_q == 4'b0000) ? ram_rdata : 32'h0;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StResp, StErr: begin
          state_q  <= StIdle;
          m0_ready <= 1'b0;
          m1_ready <= 1'b0;
          m0_rdata <= '0;
          m1_rdata <= '0;
        end
      endcase
    end
  end

  assign busy_o = (state_q != StIdle);

endmodule
